// File: rtl/arm_shift_pipe.sv
// -----------------------------------------------------------------------------
// arm_shift_pipe
//
// Pipelined ARM shifter-operand unit. It takes Rm, a shift type and an
// immediate- or register-specified amount, plus the current C flag. It
// produces the shifted operand and the shifter carry-out with full ARM
// semantics: LSL/LSR/ASR/ROR, RRX, and the #32, >32 and Rs[7:0]==0 cases.
//
// Every case is reduced at the input to one common form:
//   result = rotate_right(pre, rot)
// where "pre" is the operand with the bits that will end up as fill
// (zeros or sign) already overwritten. Those are the bits that a logical or
// arithmetic shift would discard. The carry-out is a single bit of the
// accepted operand, so it is resolved at the input as well. The
// log2(WIDTH) rotate mux levels are then split evenly across the
// PIPE_STAGES registered stages. All special-case decisions therefore
// travel with the op, and a stall cannot alter a result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline kill (clears every valid bit)
//   in_valid   / in_ready   input handshake
//   in_data    operand (Rm)
//   in_type    00 LSL, 01 LSR, 10 ASR, 11 ROR
//   in_imm     1 = immediate amount in_amt[4:0], 0 = register amount
//   in_amt     shift amount
//   in_cin     current C flag
//   out_valid  / out_ready  output handshake
//   out_data   shifted result
//   out_cout   shifter carry-out
//   perf_ops   (SHIFT_PERF_EN only) count of output transfers
//   perf_stall (SHIFT_PERF_EN only) count of cycles with out_valid && !out_ready
//
// Optional feature macro: SHIFT_PERF_EN adds the two 32-bit perf counters.
// -----------------------------------------------------------------------------
module arm_shift_pipe #(
    parameter int WIDTH       = 32,
    parameter int AMT_W       = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_type,
    input  logic             in_imm,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
`ifdef SHIFT_PERF_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam int LW = $clog2(WIDTH);
    // Amount width wide enough to also hold the 5-bit immediate field
    localparam int EW = (AMT_W > 5) ? AMT_W : 5;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Rotate right by 2**lvl (one mux level of the barrel rotator)
    function automatic logic [WIDTH-1:0] rotr_pow2(input logic [WIDTH-1:0] d, input int lvl);
        int n;
        n = 32'sd1 << lvl;
        return (d >> n) | (d << (WIDTH - n));
    endfunction

    // Pipeline stage that owns rotate level lvl; spreads levels evenly
    function automatic int level_stage(input int lvl);
        return (lvl * PIPE_STAGES) / LW;
    endfunction

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic [EW-1:0]    amt_ext_s;
    logic [EW-1:0]    amt_s;
    logic [LW-1:0]    amod_s;
    logic [LW-1:0]    amod_m1_s;
    logic [LW-1:0]    amod_neg_s;
    logic             zero_s;
    logic             lt_s;
    logic             eq_s;
    logic             sign_s;
    logic [WIDTH-1:0] pm_s;
    logic             fill_s;
    logic [LW-1:0]    dec_rot_s;
    logic             dec_cout_s;
    logic [WIDTH-1:0] pre_s;

    // Amount selection and range classification
    always_comb begin
        amt_ext_s  = EW'(in_amt);
        if (in_imm) begin
            amt_s = EW'(amt_ext_s[4:0]);
        end else begin
            amt_s = amt_ext_s;
        end
        amod_s     = amt_s[LW-1:0];
        amod_m1_s  = amod_s - {{(LW-1){1'b0}}, 1'b1};
        amod_neg_s = {LW{1'b0}} - amod_s;
        zero_s     = (amt_s == {EW{1'b0}});
        lt_s       = (amt_s <  EW'(WIDTH));
        eq_s       = (amt_s == EW'(WIDTH));
        sign_s     = in_data[WIDTH-1];
    end

    // Special-case resolution: pre-rotation fill mask, fill bit, rotate amount, carry
    always_comb begin
        pm_s       = {WIDTH{1'b0}};
        fill_s     = 1'b0;
        dec_rot_s  = {LW{1'b0}};
        dec_cout_s = in_cin;
        if (in_imm && zero_s) begin
            // Immediate #0 encodes LSL #0, LSR #32, ASR #32 and RRX
            case (shift_t'(in_type))
                SH_LSL: begin
                    dec_cout_s = in_cin;
                end
                SH_LSR: begin
                    pm_s       = {WIDTH{1'b1}};
                    dec_cout_s = sign_s;
                end
                SH_ASR: begin
                    pm_s       = {WIDTH{1'b1}};
                    fill_s     = sign_s;
                    dec_cout_s = sign_s;
                end
                SH_ROR: begin
                    // RRX: bit 0 becomes C, then rotate right by one
                    pm_s       = {{(WIDTH-1){1'b0}}, 1'b1};
                    fill_s     = in_cin;
                    dec_rot_s  = {{(LW-1){1'b0}}, 1'b1};
                    dec_cout_s = in_data[0];
                end
                default: begin
                    dec_cout_s = in_cin;
                end
            endcase
        end else if (zero_s) begin
            // Register amount of zero: pass through for every type
            dec_cout_s = in_cin;
        end else begin
            case (shift_t'(in_type))
                SH_LSL: begin
                    if (lt_s) begin
                        // The top a bits are shifted out; they wrap to the bottom as zeros
                        pm_s       = ~({WIDTH{1'b1}} >> amod_s);
                        dec_rot_s  = amod_neg_s;
                        dec_cout_s = in_data[amod_neg_s];
                    end else if (eq_s) begin
                        pm_s       = {WIDTH{1'b1}};
                        dec_cout_s = in_data[0];
                    end else begin
                        pm_s       = {WIDTH{1'b1}};
                        dec_cout_s = 1'b0;
                    end
                end
                SH_LSR: begin
                    if (lt_s) begin
                        pm_s       = ~({WIDTH{1'b1}} << amod_s);
                        dec_rot_s  = amod_s;
                        dec_cout_s = in_data[amod_m1_s];
                    end else if (eq_s) begin
                        pm_s       = {WIDTH{1'b1}};
                        dec_cout_s = sign_s;
                    end else begin
                        pm_s       = {WIDTH{1'b1}};
                        dec_cout_s = 1'b0;
                    end
                end
                SH_ASR: begin
                    if (lt_s) begin
                        pm_s       = ~({WIDTH{1'b1}} << amod_s);
                        fill_s     = sign_s;
                        dec_rot_s  = amod_s;
                        dec_cout_s = in_data[amod_m1_s];
                    end else begin
                        pm_s       = {WIDTH{1'b1}};
                        fill_s     = sign_s;
                        dec_cout_s = sign_s;
                    end
                end
                SH_ROR: begin
                    if (amod_s == {LW{1'b0}}) begin
                        // Multiple of WIDTH: data unchanged, carry is the MSB
                        dec_cout_s = sign_s;
                    end else begin
                        dec_rot_s  = amod_s;
                        dec_cout_s = in_data[amod_m1_s];
                    end
                end
                default: begin
                    dec_cout_s = in_cin;
                end
            endcase
        end
        pre_s = (in_data & ~pm_s) | (pm_s & {WIDTH{fill_s}});
    end

    // ------------------------------------------------------------------
    // Stage handshake
    // ------------------------------------------------------------------
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [PIPE_STAGES-1:0] load_s;
    logic [PIPE_STAGES-1:0] unload_s;
    logic [PIPE_STAGES-1:0] up_valid_s;
    logic [PIPE_STAGES-1:0] en_s;

    // Per-stage load/advance decisions, walked from the output back to the input
    always_comb begin
        load_s     = {PIPE_STAGES{1'b0}};
        unload_s   = {PIPE_STAGES{1'b0}};
        up_valid_s = {PIPE_STAGES{1'b0}};
        en_s       = {PIPE_STAGES{1'b0}};
        valid_d    = valid_q;
        unload_s[PIPE_STAGES-1] = valid_q[PIPE_STAGES-1] & out_ready;
        for (int s = PIPE_STAGES - 1; s > 0; s--) begin
            load_s[s]     = ~valid_q[s] | unload_s[s];
            unload_s[s-1] = valid_q[s-1] & load_s[s];
        end
        load_s[0]     = ~valid_q[0] | unload_s[0];
        in_ready      = load_s[0] & ~flush;
        up_valid_s[0] = in_valid & in_ready;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            up_valid_s[s] = valid_q[s-1];
        end
        for (int s = 0; s < PIPE_STAGES; s++) begin
            en_s[s] = load_s[s] & up_valid_s[s] & ~flush;
            if (flush) begin
                valid_d[s] = 1'b0;
            end else if (load_s[s]) begin
                valid_d[s] = up_valid_s[s];
            end else begin
                valid_d[s] = valid_q[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath stages
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_q     [PIPE_STAGES];
    logic [WIDTH-1:0] data_d     [PIPE_STAGES];
    logic [LW-1:0]    rot_q      [PIPE_STAGES];
    logic             cout_q     [PIPE_STAGES];
    logic [WIDTH-1:0] src_data_s [PIPE_STAGES];
    logic [LW-1:0]    src_rot_s  [PIPE_STAGES];
    logic             src_cout_s [PIPE_STAGES];

    // Stage inputs: decode feeds stage 0, each later stage takes its predecessor
    always_comb begin
        src_data_s[0] = pre_s;
        src_rot_s[0]  = dec_rot_s;
        src_cout_s[0] = dec_cout_s;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            src_data_s[s] = data_q[s-1];
            src_rot_s[s]  = rot_q[s-1];
            src_cout_s[s] = cout_q[s-1];
        end
    end

    // Rotate levels owned by each stage
    always_comb begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
            data_d[s] = src_data_s[s];
            for (int j = 0; j < LW; j++) begin
                if ((level_stage(j) == s) && src_rot_s[s][j]) begin
                    data_d[s] = rotr_pow2(data_d[s], j);
                end else begin
                    data_d[s] = data_d[s];
                end
            end
        end
    end

    // Stage registers; a stage only captures when a valid op moves into it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {PIPE_STAGES{1'b0}};
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= {WIDTH{1'b0}};
                rot_q[s]  <= {LW{1'b0}};
                cout_q[s] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (en_s[s]) begin
                    data_q[s] <= data_d[s];
                    rot_q[s]  <= src_rot_s[s];
                    cout_q[s] <= src_cout_s[s];
                end
            end
        end
    end

    assign out_valid = valid_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign out_cout  = cout_q[PIPE_STAGES-1];

`ifdef SHIFT_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_stall_q;

    // Transfer and stall counters; untouched by flush, wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (out_valid && out_ready) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_arm_shift_pipe.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for arm_shift_pipe (WIDTH=32, PIPE_STAGES=2).
// Expected values below are hand-computed from ARM shifter semantics.
// -----------------------------------------------------------------------------
module tb_arm_shift_pipe;

    localparam int W  = 32;
    localparam int AW = 8;
    localparam int P  = 2;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_type;
    logic          in_imm;
    logic [AW-1:0] in_amt;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_cout;
`ifdef SHIFT_PERF_EN
    logic [31:0]   perf_ops;
    logic [31:0]   perf_stall;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    arm_shift_pipe #(.WIDTH(W), .AMT_W(AW), .PIPE_STAGES(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_type   (in_type),
        .in_imm    (in_imm),
        .in_amt    (in_amt),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout)
`ifdef SHIFT_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic imm, input logic [AW-1:0] amt,
                         input logic [W-1:0] d, input logic c);
        in_type  = t;
        in_imm   = imm;
        in_amt   = amt;
        in_data  = d;
        in_cin   = c;
        in_valid = 1'b1;
    endtask

    // One op through an empty pipe: presented in cycle c, result visible in cycle c+2
    task automatic run_op(input string tag, input logic [1:0] t, input logic imm,
                          input logic [AW-1:0] amt, input logic [W-1:0] d, input logic c,
                          input logic [W-1:0] ed, input logic ec);
        out_ready = 1'b1;
        drive(t, imm, amt, d, c);
        #1;
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, out_data, ed);
        check({tag, ".cout"}, 32'(out_cout), 32'(ec));
        tick();
        check({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  op_idx;
        int  got;
        int  held;
        bit  seen_first;
        bit  saw_full;
        bit  xin;
        bit  xout;

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_type   = 2'b00;
        in_imm    = 1'b0;
        in_amt    = 8'h0;
        in_cin    = 1'b0;
        #12;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", out_data, 32'h0);
        check("rst.cout", 32'(out_cout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle.ready", 32'(in_ready), 32'd1);
        check("idle.valid", 32'(out_valid), 32'd0);

        // Immediate-mode special and normal cases
        run_op("imm_lsr0",  LSR, 1'b1, 8'd0,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        run_op("imm_rrx",   ROR, 1'b1, 8'd0,  32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
        run_op("imm_asr0",  ASR, 1'b1, 8'd0,  32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        run_op("imm_lsl0",  LSL, 1'b1, 8'd0,  32'h0000_0005, 1'b1, 32'h0000_0005, 1'b1);
        run_op("imm_lsl4",  LSL, 1'b1, 8'd4,  32'hF000_000F, 1'b0, 32'h0000_00F0, 1'b1);
        run_op("imm_asr4",  ASR, 1'b1, 8'd4,  32'h8000_0010, 1'b1, 32'hF800_0001, 1'b0);
        run_op("imm_lsl_hi",LSL, 1'b1, 8'h24, 32'h0000_0001, 1'b1, 32'h0000_0010, 1'b0);

        // Register-mode cases
        run_op("reg_lsl32", LSL, 1'b0, 8'd32, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1);
        run_op("reg_lsl33", LSL, 1'b0, 8'd33, 32'h8000_0001, 1'b1, 32'h0000_0000, 1'b0);
        run_op("reg_ror64", ROR, 1'b0, 8'd64, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1);
        run_op("reg_amt0",  LSR, 1'b0, 8'd0,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0);
        run_op("reg_lsr32", LSR, 1'b0, 8'd32, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        run_op("reg_lsr1",  LSR, 1'b0, 8'd1,  32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1);
        run_op("reg_asr40", ASR, 1'b0, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_op("reg_ror8",  ROR, 1'b0, 8'd8,  32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0);
        run_op("reg_ror33", ROR, 1'b0, 8'd33, 32'h0000_0003, 1'b0, 32'h8000_0001, 1'b1);

        // Back-to-back 4 ops (LSL #1 of 1..4), output stalled 3 cycles after first result
        op_idx     = 0;
        got        = 0;
        held       = 0;
        seen_first = 1'b0;
        saw_full   = 1'b0;
        out_ready  = 1'b0;
        drive(LSL, 1'b1, 8'd1, 32'd1, 1'b0);
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (out_valid && !seen_first) begin
                seen_first = 1'b1;
            end
            if (seen_first && held < 3) begin
                out_ready = 1'b0;
                held++;
                check("bp.hold_valid", 32'(out_valid), 32'd1);
                check("bp.hold_data", out_data, 32'd2);
            end else if (seen_first) begin
                out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) begin
                saw_full = 1'b1;
            end
            xin  = in_valid && in_ready;
            xout = out_valid && out_ready;
            if (xout) begin
                check("bp.order", out_data, 32'((got + 1) * 2));
                got++;
            end
            @(posedge clk);
            #1;
            if (xin) begin
                op_idx++;
                if (op_idx < 4) begin
                    drive(LSL, 1'b1, 8'd1, 32'(op_idx + 1), 1'b0);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp.count", 32'(got), 32'd4);
        check("bp.held", 32'(held), 32'd3);
        check("bp.full", 32'(saw_full), 32'd1);
        tick();
        check("bp.nodup", 32'(out_valid), 32'd0);

        // Flush with two ops in flight and a third presented
        out_ready = 1'b0;
        drive(LSL, 1'b1, 8'd1, 32'd1, 1'b0);
        tick();
        drive(LSL, 1'b1, 8'd1, 32'd2, 1'b0);
        tick();
        check("fl.pre_valid", 32'(out_valid), 32'd1);
        drive(LSL, 1'b1, 8'd1, 32'd3, 1'b0);
        flush = 1'b1;
        #1;
        check("fl.ready", 32'(in_ready), 32'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fl.valid0", 32'(out_valid), 32'd0);
        tick();
        check("fl.valid1", 32'(out_valid), 32'd0);
        run_op("fl.after", ROR, 1'b0, 8'd4, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1);

        // Asynchronous reset between edges while a result is on the output
        out_ready = 1'b0;
        drive(ROR, 1'b0, 8'd4, 32'h0000_000F, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("ar.before", out_data, 32'hF000_0000);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.data", out_data, 32'h0);
        check("ar.cout", 32'(out_cout), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar.after", 32'(out_valid), 32'd0);
`ifdef SHIFT_PERF_EN
        check("perf.ops0", perf_ops, 32'd0);
        for (int k = 0; k < 5; k++) begin
            run_op("perf.op", LSR, 1'b0, 8'd1, 32'(k * 4), 1'b0, 32'(k * 2), 1'b0);
        end
        check("perf.ops5", perf_ops, 32'd5);
        check("perf.stall", perf_stall, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
